// File: rtl/gate_arbiter.sv
// Parking gate arbiter: queues entry/exit requests, grants one at a time and holds the gate open.
// Optional served_count statistics output enabled by defining GATE_ARBITER_STATS_EN.
module gate_arbiter #(
  parameter int unsigned OPEN_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic [3:0] spots,
  output logic [2:0] alloc_slot,
  output logic       gate_open,
  output logic       entry_grant,
  output logic       exit_grant,
  output logic       reject,
  output logic       full,
`ifdef GATE_ARBITER_STATS_EN
  output logic       busy,
  output logic [7:0] served_count
`else
  output logic       busy
`endif
);

  typedef enum logic [1:0] {StIdle, StOpen, StClose} state_e;

  localparam logic [3:0] OpenTicks = 4'(OPEN_TICKS);

  state_e     state_q, state_d;
  logic [3:0] spots_q, spots_d;
  logic [2:0] alloc_q, alloc_d;
  logic       entry_pend_q, entry_pend_d;
  logic       exit_pend_q, exit_pend_d;
  logic [1:0] slot_q, slot_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic       entry_grant_q, entry_grant_d;
  logic       exit_grant_q, exit_grant_d;
  logic       reject_q, reject_d;
  logic       last_entry_q, last_entry_d;
  logic       entry_clr, exit_clr;
  logic [1:0] free_idx;

  assign full = (spots_q == 4'b1111);

  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!spots_q[i]) free_idx = 2'(i);
    end
  end

  always_comb begin
    state_d       = state_q;
    spots_d       = spots_q;
    alloc_d       = alloc_q;
    tick_cnt_d    = tick_cnt_q;
    last_entry_d  = last_entry_q;
    entry_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    reject_d      = 1'b0;
    entry_clr     = 1'b0;
    exit_clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Tie goes to the type not served last.
        if (entry_pend_q && (!exit_pend_q || !last_entry_q)) begin
          entry_clr    = 1'b1;
          last_entry_d = 1'b1;
          if (!full) begin
            spots_d[free_idx] = 1'b1;
            alloc_d           = {1'b0, free_idx} + 3'd1;
            entry_grant_d     = 1'b1;
            tick_cnt_d        = 4'd0;
            state_d           = StOpen;
          end else begin
            reject_d = 1'b1;
          end
        end else if (exit_pend_q) begin
          exit_clr     = 1'b1;
          last_entry_d = 1'b0;
          if (spots_q[slot_q]) begin
            spots_d[slot_q] = 1'b0;
            exit_grant_d    = 1'b1;
            tick_cnt_d      = 4'd0;
            state_d         = StOpen;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StOpen: begin
        if (tick_1Hz) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_d == OpenTicks) state_d = StClose;
        end
      end
      StClose: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    entry_pend_d = (entry_pend_q && !entry_clr) || entry_req;
    // A held exit keeps its first slot unless it is being consumed this cycle.
    if (exit_req && (!exit_pend_q || exit_clr)) begin
      exit_pend_d = 1'b1;
      slot_d      = exit_slot;
    end else begin
      exit_pend_d = exit_pend_q && !exit_clr;
      slot_d      = slot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      spots_q       <= 4'd0;
      alloc_q       <= 3'd0;
      entry_pend_q  <= 1'b0;
      exit_pend_q   <= 1'b0;
      slot_q        <= 2'd0;
      tick_cnt_q    <= 4'd0;
      entry_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      reject_q      <= 1'b0;
      last_entry_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      spots_q       <= spots_d;
      alloc_q       <= alloc_d;
      entry_pend_q  <= entry_pend_d;
      exit_pend_q   <= exit_pend_d;
      slot_q        <= slot_d;
      tick_cnt_q    <= tick_cnt_d;
      entry_grant_q <= entry_grant_d;
      exit_grant_q  <= exit_grant_d;
      reject_q      <= reject_d;
      last_entry_q  <= last_entry_d;
    end
  end

`ifdef GATE_ARBITER_STATS_EN
  logic [7:0] served_q, served_d;

  always_comb begin
    served_d = served_q;
    if ((entry_grant_d || exit_grant_d) && (served_q != 8'hFF)) served_d = served_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) served_q <= 8'd0;
    else        served_q <= served_d;
  end

  assign served_count = served_q;
`endif

  assign spots       = spots_q;
  assign alloc_slot  = alloc_q;
  assign gate_open   = (state_q == StOpen);
  assign busy        = (state_q != StIdle);
  assign entry_grant = entry_grant_q;
  assign exit_grant  = exit_grant_q;
  assign reject      = reject_q;

endmodule

// File: tb/tb_gate_arbiter.sv
// Scoreboard bench for gate_arbiter: expected grant/reject events are queued as stimulus is
// driven and popped when the DUT pulses a grant or reject.
module tb_gate_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1Hz = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic [1:0] exit_slot = 2'd0;
  logic [3:0] spots;
  logic [2:0] alloc_slot;
  logic       gate_open, entry_grant, exit_grant, reject, full, busy;
`ifdef GATE_ARBITER_STATS_EN
  logic [7:0] served_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  // {entry_grant, exit_grant, reject, spots, alloc_slot}
  logic [9:0] sb_q[$];
  logic [9:0] got, want;
  bit         ok;

  gate_arbiter #(.OPEN_TICKS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1Hz    (tick_1Hz),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .exit_slot   (exit_slot),
    .spots       (spots),
    .alloc_slot  (alloc_slot),
    .gate_open   (gate_open),
    .entry_grant (entry_grant),
    .exit_grant  (exit_grant),
    .reject      (reject),
    .full        (full),
`ifdef GATE_ARBITER_STATS_EN
    .busy        (busy),
    .served_count(served_count)
`else
    .busy        (busy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic pulse_entry();
    entry_req = 1'b1;
    step(1);
    entry_req = 1'b0;
  endtask

  task automatic pulse_exit(input logic [1:0] s);
    exit_req  = 1'b1;
    exit_slot = s;
    step(1);
    exit_req  = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1Hz = 1'b1;
      step(1);
      tick_1Hz = 1'b0;
    end
  endtask

  task automatic wait_evt(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (entry_grant || exit_grant || reject) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    got = {entry_grant, exit_grant, reject, spots, alloc_slot};
    if (got !== 10'd0 || gate_open !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b gate=%b busy=%b full=%b want all zero",
               got, gate_open, busy, full);
    end
  endtask

  task automatic test_entry();
    sb_q.push_back({3'b100, 4'b0001, 3'd1});
    pulse_entry();
    tick_1Hz = 1'b1;  // lands on the grant edge, must not count
    wait_evt(ok);
    tick_1Hz = 1'b0;
    got = {entry_grant, exit_grant, reject, spots, alloc_slot};
    want = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== want || gate_open !== 1'b1) begin
      n_errors++;
      $display("FAIL entry_grant: got %b gate=%b want %b gate=1", got, gate_open, want);
    end
    tick_n(2);
    n_checks++;
    if (gate_open !== 1'b1) begin
      n_errors++;
      $display("FAIL entry_open_2ticks: gate_open=%b want 1", gate_open);
    end
    tick_n(1);
    n_checks++;
    if (gate_open !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL entry_close: gate=%b busy=%b want gate=0 busy=1", gate_open, busy);
    end
    step(1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL entry_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_exit();
    sb_q.push_back({3'b001, 4'b0001, 3'd1});
    sb_q.push_back({3'b010, 4'b0000, 3'd1});
    pulse_exit(2'd2);
    wait_evt(ok);
    got = {entry_grant, exit_grant, reject, spots, alloc_slot};
    want = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== want || gate_open !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL exit_reject: got %b gate=%b busy=%b want %b gate=0 busy=0",
               got, gate_open, busy, want);
    end
    pulse_exit(2'd0);
    wait_evt(ok);
    got = {entry_grant, exit_grant, reject, spots, alloc_slot};
    want = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== want || gate_open !== 1'b1) begin
      n_errors++;
      $display("FAIL exit_grant: got %b gate=%b want %b gate=1", got, gate_open, want);
    end
    tick_n(3);
    step(1);
  endtask

  task automatic test_tie();
    do_reset();
    sb_q.push_back({3'b100, 4'b0001, 3'd1});
    sb_q.push_back({3'b001, 4'b0001, 3'd1});
    sb_q.push_back({3'b100, 4'b0011, 3'd2});
    sb_q.push_back({3'b010, 4'b0010, 3'd2});
    pulse_entry();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) pulse_exit(2'd3);
      if (k == 2) begin
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 2'd0;
        step(1);
        entry_req = 1'b0;
        exit_req  = 1'b0;
      end
      wait_evt(ok);
      got = {entry_grant, exit_grant, reject, spots, alloc_slot};
      want = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== want) begin
        n_errors++;
        $display("FAIL tie_event%0d: got %b want %b", k, got, want);
      end
      if (k != 1) tick_n(3);
    end
    step(1);
  endtask

  task automatic test_full();
    logic [3:0] exp_spots[3] = '{4'b0011, 4'b0111, 4'b1111};
    logic [2:0] exp_alloc[3] = '{3'd1, 3'd3, 3'd4};
    for (int k = 0; k < 3; k++) sb_q.push_back({3'b100, exp_spots[k], exp_alloc[k]});
    sb_q.push_back({3'b001, 4'b1111, 3'd4});
    for (int k = 0; k < 4; k++) begin
      pulse_entry();
      wait_evt(ok);
      got = {entry_grant, exit_grant, reject, spots, alloc_slot};
      want = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== want) begin
        n_errors++;
        $display("FAIL fill%0d: got %b want %b", k, got, want);
      end
      if (k < 3) begin
        tick_n(3);
        step(1);
      end
    end
    n_checks++;
    if (gate_open !== 1'b0 || full !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL full_reject_state: gate=%b full=%b busy=%b want 0 1 0",
               gate_open, full, busy);
    end
  endtask

  task automatic test_reset_mid_open();
    int evts;
    sb_q.push_back({3'b010, 4'b1101, 3'd4});
    pulse_exit(2'd1);
    wait_evt(ok);
    got = {entry_grant, exit_grant, reject, spots, alloc_slot};
    want = sb_q.pop_front();
    n_checks++;
    if (!ok || got !== want) begin
      n_errors++;
      $display("FAIL pre_reset_exit: got %b want %b", got, want);
    end
    tick_n(1);
    reset = 1'b0;
    entry_req = 1'b1;
    step(1);
    reset = 1'b1;
    entry_req = 1'b0;
    n_checks++;
    if (gate_open !== 1'b0 || spots !== 4'd0 || busy !== 1'b0 || alloc_slot !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_mid_open: gate=%b spots=%b busy=%b alloc=%0d want 0 0000 0 0",
               gate_open, spots, busy, alloc_slot);
    end
    evts = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (entry_grant || exit_grant || reject) evts++;
    end
    n_checks++;
    if (evts != 0) begin
      n_errors++;
      $display("FAIL reset_discard_req: events=%0d want 0", evts);
    end
  endtask

  task automatic test_back_to_back();
    int evts;
    sb_q.push_back({3'b100, 4'b0001, 3'd1});
    sb_q.push_back({3'b010, 4'b0000, 3'd1});
    sb_q.push_back({3'b100, 4'b0001, 3'd1});
    pulse_entry();
    for (int k = 0; k < 3; k++) begin
      wait_evt(ok);
      got = {entry_grant, exit_grant, reject, spots, alloc_slot};
      want = sb_q.pop_front();
      n_checks++;
      if (!ok || got !== want) begin
        n_errors++;
        $display("FAIL b2b_event%0d: got %b want %b", k, got, want);
      end
      if (k == 0) begin
        pulse_entry();
        pulse_entry();
        pulse_exit(2'd0);
        pulse_exit(2'd1);
      end
      tick_n(3);
    end
    evts = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (entry_grant || exit_grant || reject) evts++;
    end
    n_checks++;
    if (evts != 0) begin
      n_errors++;
      $display("FAIL b2b_absorbed: extra events=%0d want 0", evts);
    end
  endtask

`ifdef GATE_ARBITER_STATS_EN
  task automatic test_stats();
    int grants;
    do_reset();
    grants = 0;
    tick_1Hz = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) pulse_entry();
      else            pulse_exit(2'd0);
      wait_evt(ok);
      if (ok && (entry_grant || exit_grant)) grants++;
    end
    tick_1Hz = 1'b0;
    step(2);
    n_checks++;
    if (grants != 300 || served_count !== 8'd255) begin
      n_errors++;
      $display("FAIL stats_saturate: grants=%0d served_count=%0d want 300 255",
               grants, served_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_tie();
    test_full();
    test_reset_mid_open();
    test_back_to_back();
`ifdef GATE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
